// File: rtl/proofcomb_pkg.sv
// rtl/proofcomb_pkg.sv - shared states, default widths and first-failure record for proofcomb_checker
package proofcomb_pkg;

  localparam int OPW_DEF   = 4;
  localparam int RW_DEF    = OPW_DEF + 1;
  localparam int CNT_W_DEF = 16;
  localparam int WCNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_CHECK,
    ST_DONE
  } state_e;

  // First-failure record at the default operand/result widths, as seen by the harnesses.
  typedef struct packed {
    logic [OPW_DEF-1:0] num1;
    logic [OPW_DEF-1:0] num2;
    logic [RW_DEF-1:0]  exp;
    logic [RW_DEF-1:0]  got;
  } fail_rec_t;

  function automatic logic [WCNT_W-1:0] warm_load(input int warmup);
    return (warmup > 0) ? WCNT_W'(warmup - 1) : '0;
  endfunction

endpackage

// File: rtl/proofcomb_align_pipe.sv
// rtl/proofcomb_align_pipe.sv - LAT-deep delay line whose valid chain tracks fill since the last clear
module proofcomb_align_pipe #(
  parameter int LAT = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  logic [W-1:0]   data_q [LAT];
  logic [W-1:0]   data_d [LAT];
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_d;

  // Data always shifts; the entry captured on the clearing edge itself is not counted.
  always_comb begin
    data_d[0] = din;
    vld_d[0]  = ~clr;
    for (int i = 1; i < LAT; i++) begin
      data_d[i] = data_q[i-1];
      vld_d[i]  = vld_q[i-1] & ~clr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) data_q[i] <= '0;
      vld_q <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) data_q[i] <= data_d[i];
      vld_q <= vld_d;
    end
  end

  assign dout = data_q[LAT-1];
  assign full = vld_q[LAT-1];

endmodule

// File: rtl/proofcomb_checker.sv
// rtl/proofcomb_checker.sv - golden-vs-test sum checker with warm-up, counters and first-failure capture
// Optional PROOFCOMB_ASSERT_EN adds an immediate assertion on every counted sample.
module proofcomb_checker
  import proofcomb_pkg::*;
#(
  parameter int OPW    = OPW_DEF,
  parameter int RW     = RW_DEF,
  parameter int LAT    = 1,
  parameter int WARMUP = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [OPW-1:0]   num1,
  input  logic [OPW-1:0]   num2,
  input  logic [OPW-1:0]   a_num1,
  input  logic [OPW-1:0]   a_num2,
  input  logic [RW-1:0]    out,
  input  logic [RW-1:0]    result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             fail_valid,
  output logic [OPW-1:0]   fail_num1,
  output logic [OPW-1:0]   fail_num2,
  output logic [RW-1:0]    fail_exp,
  output logic [RW-1:0]    fail_got
);

  localparam int              PW        = 1 + 2 * OPW + RW;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WCNT_W-1:0] WLOAD   = warm_load(WARMUP);
  localparam state_e          RUN_ENTRY = (WARMUP > 0) ? ST_WARMUP : ST_CHECK;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   checked_q, checked_d;
  logic [CNT_W-1:0]   mism_q, mism_d;
  logic               fvalid_q, fvalid_d;
  logic [OPW-1:0]     fnum1_q, fnum1_d;
  logic [OPW-1:0]     fnum2_q, fnum2_d;
  logic [RW-1:0]      fexp_q, fexp_d;
  logic [RW-1:0]      fgot_q, fgot_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               err_q, err_d;

  logic               start_acc;
  logic [PW-1:0]      pipe_in, pipe_out;
  logic               tail_full;
  logic               tail_match;
  logic [OPW-1:0]     tail_num1, tail_num2;
  logic [RW-1:0]      tail_out;
  logic               counted;
  logic               miscompare;

  assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign pipe_in   = {(num1 == a_num1) && (num2 == a_num2), num1, num2, out};

  proofcomb_align_pipe #(
    .LAT (LAT),
    .W   (PW)
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .din  (pipe_in),
    .dout (pipe_out),
    .full (tail_full)
  );

  assign {tail_match, tail_num1, tail_num2, tail_out} = pipe_out;
  assign counted    = (state_q == ST_CHECK) && tail_full && tail_match;
  assign miscompare = counted && (tail_out != result);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    checked_d = checked_q;
    mism_d    = mism_q;
    fvalid_d  = fvalid_q;
    fnum1_d   = fnum1_q;
    fnum2_d   = fnum2_q;
    fexp_d    = fexp_q;
    fgot_d    = fgot_q;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = RUN_ENTRY;
          wcnt_d    = WLOAD;
          checked_d = '0;
          mism_d    = '0;
          fvalid_d  = 1'b0;
          fnum1_d   = '0;
          fnum2_d   = '0;
          fexp_d    = '0;
          fgot_d    = '0;
        end
      end
      ST_WARMUP: begin
        if (stop)              state_d = ST_DONE;
        else if (wcnt_q == '0) state_d = ST_CHECK;
        else                   wcnt_d  = wcnt_q - 1'b1;
      end
      ST_CHECK: begin
        // A sample coinciding with stop is still scored before leaving.
        if (counted && checked_q != '1) checked_d = checked_q + CNT_ONE;
        if (miscompare) begin
          err_d = 1'b1;
          if (mism_q != '1) mism_d = mism_q + CNT_ONE;
          if (!fvalid_q) begin
            fvalid_d = 1'b1;
            fnum1_d  = tail_num1;
            fnum2_d  = tail_num2;
            fexp_d   = tail_out;
            fgot_d   = result;
          end
        end
        if (stop) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_WARMUP) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (mism_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      checked_q <= '0;
      mism_q    <= '0;
      fvalid_q  <= 1'b0;
      fnum1_q   <= '0;
      fnum2_q   <= '0;
      fexp_q    <= '0;
      fgot_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      checked_q <= checked_d;
      mism_q    <= mism_d;
      fvalid_q  <= fvalid_d;
      fnum1_q   <= fnum1_d;
      fnum2_q   <= fnum2_d;
      fexp_q    <= fexp_d;
      fgot_q    <= fgot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
    end
  end

`ifdef PROOFCOMB_ASSERT_EN
  always @(posedge clk) begin
    if (!rst && counted) begin
      assert (result == tail_out);
    end
  end
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err          = err_q;
  assign checked_cnt  = checked_q;
  assign mismatch_cnt = mism_q;
  assign fail_valid   = fvalid_q;
  assign fail_num1    = fnum1_q;
  assign fail_num2    = fnum2_q;
  assign fail_exp     = fexp_q;
  assign fail_got     = fgot_q;

endmodule

// File: tb/tb_proofcomb_checker.sv
// tb/tb_proofcomb_checker.sv - directed vectors for proofcomb_checker (16-bit and 4-bit counter builds)
module tb_proofcomb_checker;
  import proofcomb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop;
  logic [3:0]  num1, num2, a_num1, a_num2;
  logic [4:0]  out, result;

  logic        busy_w, done_w, pass_w, err_w, fvalid_w;
  logic [15:0] checked_w, mism_w;
  logic [3:0]  fnum1_w, fnum2_w;
  logic [4:0]  fexp_w, fgot_w;

  logic        busy_n, done_n, pass_n, err_n, fvalid_n;
  logic [3:0]  checked_n, mism_n;
  logic [3:0]  fnum1_n, fnum2_n;
  logic [4:0]  fexp_n, fgot_n;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          err_seen;
  fail_rec_t   exp_rec;

  assign out = {1'b0, num1} + {1'b0, num2};

  always #5 clk = ~clk;

  proofcomb_checker #(.OPW(4), .RW(5), .LAT(1), .WARMUP(1), .CNT_W(16)) dut_w (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .num1(num1), .num2(num2), .a_num1(a_num1), .a_num2(a_num2),
    .out(out), .result(result),
    .busy(busy_w), .done(done_w), .pass(pass_w), .err(err_w),
    .checked_cnt(checked_w), .mismatch_cnt(mism_w), .fail_valid(fvalid_w),
    .fail_num1(fnum1_w), .fail_num2(fnum2_w), .fail_exp(fexp_w), .fail_got(fgot_w)
  );

  proofcomb_checker #(.OPW(4), .RW(5), .LAT(1), .WARMUP(1), .CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .num1(num1), .num2(num2), .a_num1(a_num1), .a_num2(a_num2),
    .out(out), .result(result),
    .busy(busy_n), .done(done_n), .pass(pass_n), .err(err_n),
    .checked_cnt(checked_n), .mismatch_cnt(mism_n), .fail_valid(fvalid_n),
    .fail_num1(fnum1_n), .fail_num2(fnum2_n), .fail_exp(fexp_n), .fail_got(fgot_n)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs are applied 1ns after an edge and outputs sampled 1ns after the next one.
  task automatic cyc(input logic [3:0] n1, input logic [3:0] n2, input logic [3:0] a1,
                     input logic [3:0] a2, input logic [4:0] res, input logic st, input logic sp);
    num1 = n1; num2 = n2; a_num1 = a1; a_num2 = a2;
    result = res; start = st; stop = sp;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    err_seen += int'(err_w);
  endtask

  task automatic check_all_zero(input string tag);
    expect_eq({tag, "_busy"}, busy_w, 0);
    expect_eq({tag, "_done"}, done_w, 0);
    expect_eq({tag, "_pass"}, pass_w, 0);
    expect_eq({tag, "_err"}, err_w, 0);
    expect_eq({tag, "_checked"}, checked_w, 0);
    expect_eq({tag, "_mism"}, mism_w, 0);
    expect_eq({tag, "_fvalid"}, fvalid_w, 0);
    expect_eq({tag, "_frec"}, {fnum1_w, fnum2_w, fexp_w, fgot_w}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    num1 = '0; num2 = '0; a_num1 = '0; a_num2 = '0; result = '0;
    err_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    cyc(3, 4, 3, 4, 7, 0, 1);
    expect_eq("idle_stop_done", done_w, 0);
    expect_eq("idle_stop_busy", busy_w, 0);

    // Correct DUT, 10 samples after start; the first falls in warm-up. Start mid-run is ignored.
    cyc(3, 4, 3, 4, 0, 1, 0);
    expect_eq("t1_busy_rise", busy_w, 1);
    for (int i = 1; i <= 10; i++) cyc(3, 4, 3, 4, 7, (i == 5), (i == 10));
    expect_eq("t1_checked", checked_w, 9);
    expect_eq("t1_mism", mism_w, 0);
    expect_eq("t1_done", done_w, 1);
    expect_eq("t1_pass", pass_w, 1);
    expect_eq("t1_busy", busy_w, 0);

    // Wrong sum 8 on the 5th counted sample.
    cyc(3, 4, 3, 4, 0, 1, 0);
    expect_eq("t2_cleared", checked_w, 0);
    err_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(3, 4, 3, 4, (i == 6) ? 5'd8 : 5'd7, 0, (i == 8));
      if (i == 6) expect_eq("t2_err_pulse", err_w, 1);
    end
    expect_eq("t2_err_count", err_seen, 1);
    expect_eq("t2_fnum1", fnum1_w, 3);
    expect_eq("t2_fnum2", fnum2_w, 4);
    expect_eq("t2_fexp", fexp_w, 7);
    expect_eq("t2_fgot", fgot_w, 8);
    expect_eq("t2_checked", checked_w, 7);
    expect_eq("t2_pass", pass_w, 0);
    expect_eq("t2_done", done_w, 1);

    // Two mismatches: only the first is recorded.
    cyc(3, 4, 3, 4, 0, 1, 0);
    expect_eq("t3_fvalid_clr", fvalid_w, 0);
    err_seen = 0;
    cyc(9, 9, 9, 9, 7, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(3, 4, 3, 4, 3, 0, 0);
    cyc(3, 4, 3, 4, 7, 0, 1);
    exp_rec = '{num1: 4'd9, num2: 4'd9, exp: 5'd18, got: 5'd0};
    expect_eq("t3_mism", mism_w, 2);
    expect_eq("t3_checked", checked_w, 3);
    expect_eq("t3_frec", {fnum1_w, fnum2_w, fexp_w, fgot_w}, exp_rec);
    expect_eq("t3_fvalid", fvalid_w, 1);
    expect_eq("t3_err_count", err_seen, 2);

    // Operands of the path under test never match the golden operands.
    cyc(3, 4, 5, 4, 0, 1, 0);
    err_seen = 0;
    for (int i = 1; i <= 6; i++) cyc(3, 4, 5, 4, 9, 0, (i == 6));
    expect_eq("t4_checked", checked_w, 0);
    expect_eq("t4_err_count", err_seen, 0);
    expect_eq("t4_pass", pass_w, 1);

    // Stop during warm-up.
    cyc(3, 4, 3, 4, 0, 1, 0);
    cyc(3, 4, 3, 4, 0, 0, 1);
    expect_eq("t4w_done", done_w, 1);
    expect_eq("t4w_pass", pass_w, 1);
    expect_eq("t4w_checked", checked_w, 0);

    // 20 mismatching samples: 4-bit counters saturate.
    cyc(3, 4, 3, 4, 0, 1, 0);
    for (int i = 1; i <= 21; i++) cyc(3, 4, 3, 4, 0, 0, (i == 21));
    expect_eq("t5_mism_w", mism_w, 20);
    expect_eq("t5_mism_n", mism_n, 15);
    expect_eq("t5_checked_n", checked_n, 15);
    expect_eq("t5_pass_n", pass_n, 0);

    // Asynchronous reset in CHECK, then a clean run.
    cyc(3, 4, 3, 4, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(3, 4, 3, 4, 0, 0, 0);
    expect_eq("t6_mism_pre", mism_w, 3);
    rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(3, 4, 3, 4, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(3, 4, 3, 4, 7, 0, (i == 4));
    expect_eq("t6_checked", checked_w, 3);
    expect_eq("t6_mism", mism_w, 0);
    expect_eq("t6_pass", pass_w, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
